// File: rtl/digdug_video_timing_if.sv
// Video timing bundle between digdug_video_timing (master) and the core/video path (slave).
// DIGDUG_HVOFFSET_EN adds the H_OFS/V_OFS sync offset inputs.
interface digdug_video_timing_if;
  logic       PCLK_EN;
  logic [8:0] PH;
  logic [8:0] PV;
  logic       HSYNC;
  logic       VSYNC;
  logic       HBLANK;
  logic       VBLANK;
  logic       FRAME;
`ifdef DIGDUG_HVOFFSET_EN
  logic [3:0] H_OFS;
  logic [3:0] V_OFS;

  modport master (output PCLK_EN, PH, PV, HSYNC, VSYNC, HBLANK, VBLANK, FRAME,
                  input  H_OFS, V_OFS);
  modport slave  (input  PCLK_EN, PH, PV, HSYNC, VSYNC, HBLANK, VBLANK, FRAME,
                  output H_OFS, V_OFS);
`else
  modport master (output PCLK_EN, PH, PV, HSYNC, VSYNC, HBLANK, VBLANK, FRAME);
  modport slave  (input  PCLK_EN, PH, PV, HSYNC, VSYNC, HBLANK, VBLANK, FRAME);
`endif
endinterface

// File: rtl/digdug_video_timing.sv
// DigDug raster timing: MCLK divider, PH/PV counters, sync/blank/frame strobes.
// Optional DIGDUG_HVOFFSET_EN: per-frame signed shift of the sync windows.
module digdug_video_timing #(
  parameter int CLK_DIV  = 8,
  parameter int H_TOTAL  = 384,
  parameter int V_TOTAL  = 264,
  parameter int H_ACTIVE = 288,
  parameter int V_ACTIVE = 224,
  parameter int HS_START = 304,
  parameter int HS_WIDTH = 32,
  parameter int VS_START = 240,
  parameter int VS_WIDTH = 8
) (
  input  logic                          MCLK,
  input  logic                          RESET,
  digdug_video_timing_if.master         vid
);

  logic [3:0] div_r;
  logic [8:0] ph_r;
  logic [8:0] pv_r;
  logic       pclk_en_r;
  logic       hsync_r;
  logic       vsync_r;
  logic       hblank_r;
  logic       vblank_r;
  logic       frame_r;

  logic       tick_s;
  logic [8:0] ph_nxt_s;
  logic [8:0] pv_nxt_s;
  logic [3:0] h_ofs_s;
  logic [3:0] v_ofs_s;
  logic [9:0] hs_lo_s;
  logic [9:0] vs_lo_s;
  logic       hsync_nxt_s;
  logic       vsync_nxt_s;

`ifdef DIGDUG_HVOFFSET_EN
  logic [3:0] h_ofs_r;
  logic [3:0] v_ofs_r;

  // Offsets are latched only while FRAME is high so a whole frame uses one value.
  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      h_ofs_r <= 4'd0;
      v_ofs_r <= 4'd0;
    end else if (frame_r) begin
      h_ofs_r <= vid.H_OFS;
      v_ofs_r <= vid.V_OFS;
    end else begin
      h_ofs_r <= h_ofs_r;
      v_ofs_r <= v_ofs_r;
    end
  end

  assign h_ofs_s = h_ofs_r;
  assign v_ofs_s = v_ofs_r;
`else
  assign h_ofs_s = 4'd0;
  assign v_ofs_s = 4'd0;
`endif

  // Next raster position plus sync decode on that next position.
  always_comb begin
    tick_s   = (div_r == 4'(CLK_DIV - 1));
    ph_nxt_s = ph_r;
    pv_nxt_s = pv_r;
    if (tick_s) begin
      if (ph_r == 9'(H_TOTAL - 1)) begin
        ph_nxt_s = 9'd0;
        if (pv_r == 9'(V_TOTAL - 1)) begin
          pv_nxt_s = 9'd0;
        end else begin
          pv_nxt_s = pv_r + 9'd1;
        end
      end else begin
        ph_nxt_s = ph_r + 9'd1;
      end
    end else begin
      ph_nxt_s = ph_r;
      pv_nxt_s = pv_r;
    end
    // Sign-extend the 4-bit offsets; legal parameter sets never wrap.
    hs_lo_s     = 10'(HS_START) + {{6{h_ofs_s[3]}}, h_ofs_s};
    vs_lo_s     = 10'(VS_START) + {{6{v_ofs_s[3]}}, v_ofs_s};
    hsync_nxt_s = ({1'b0, ph_nxt_s} >= hs_lo_s) &&
                  ({1'b0, ph_nxt_s} < (hs_lo_s + 10'(HS_WIDTH)));
    vsync_nxt_s = ({1'b0, pv_nxt_s} >= vs_lo_s) &&
                  ({1'b0, pv_nxt_s} < (vs_lo_s + 10'(VS_WIDTH)));
  end

  // All timing state and outputs.
  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      div_r     <= 4'd0;
      ph_r      <= 9'd0;
      pv_r      <= 9'd0;
      pclk_en_r <= 1'b0;
      hsync_r   <= 1'b0;
      vsync_r   <= 1'b0;
      hblank_r  <= 1'b0;
      vblank_r  <= 1'b0;
      frame_r   <= 1'b0;
    end else begin
      div_r     <= tick_s ? 4'd0 : (div_r + 4'd1);
      pclk_en_r <= tick_s;
      ph_r      <= ph_nxt_s;
      pv_r      <= pv_nxt_s;
      hsync_r   <= hsync_nxt_s;
      vsync_r   <= vsync_nxt_s;
      hblank_r  <= (ph_nxt_s >= 9'(H_ACTIVE));
      vblank_r  <= (pv_nxt_s >= 9'(V_ACTIVE));
      frame_r   <= tick_s && (ph_nxt_s == 9'd0) && (pv_nxt_s == 9'd0);
    end
  end

  assign vid.PCLK_EN = pclk_en_r;
  assign vid.PH      = ph_r;
  assign vid.PV      = pv_r;
  assign vid.HSYNC   = hsync_r;
  assign vid.VSYNC   = vsync_r;
  assign vid.HBLANK  = hblank_r;
  assign vid.VBLANK  = vblank_r;
  assign vid.FRAME   = frame_r;

endmodule

// File: tb/tb_digdug_video_timing.sv
// Randomized bench: a shrunk-raster instance (many frames, random resets/offsets)
// and a default-parameter instance, both checked against a pixel-count model.
module tb_digdug_video_timing;

  localparam int S_D  = 3;
  localparam int S_HT = 32;
  localparam int S_VT = 20;
  localparam int S_HA = 20;
  localparam int S_VA = 10;
  localparam int S_HS = 22;
  localparam int S_HW = 3;
  localparam int S_VS = 11;
  localparam int S_VW = 2;

  typedef struct {
    int pclk;
    int ph;
    int pv;
    int hs;
    int vs;
    int hb;
    int vb;
    int fr;
  } exp_t;

  logic MCLK = 1'b0;
  logic RESET = 1'b1;
  int   n = 0;
  int   eff_h = 0;
  int   eff_v = 0;
  int   checks = 0;
  int   failures = 0;
  bit   done = 1'b0;

  digdug_video_timing_if s_if ();
  digdug_video_timing_if d_if ();

  digdug_video_timing #(
    .CLK_DIV(S_D), .H_TOTAL(S_HT), .V_TOTAL(S_VT), .H_ACTIVE(S_HA), .V_ACTIVE(S_VA),
    .HS_START(S_HS), .HS_WIDTH(S_HW), .VS_START(S_VS), .VS_WIDTH(S_VW)
  ) dut_s (.MCLK(MCLK), .RESET(RESET), .vid(s_if.master));

  digdug_video_timing dut_d (.MCLK(MCLK), .RESET(RESET), .vid(d_if.master));

`ifdef DIGDUG_HVOFFSET_EN
  int h_drv = 0;
  int v_drv = 0;
  assign s_if.H_OFS = h_drv[3:0];
  assign s_if.V_OFS = v_drv[3:0];
  assign d_if.H_OFS = 4'd0;
  assign d_if.V_OFS = 4'd0;
`endif

  always #5 MCLK = ~MCLK;

  // Expected outputs n MCLK edges after reset release, from plain pixel arithmetic.
  function automatic exp_t model(input int cyc, input int d, input int ht, input int vt,
                                 input int ha, input int va, input int hs, input int hw,
                                 input int vs, input int vw, input int ho, input int vo);
    exp_t e;
    int   p;
    e = '{default: 0};
    if (cyc > 0) begin
      p      = cyc / d;
      e.pclk = (cyc % d == 0) ? 1 : 0;
      e.ph   = p % ht;
      e.pv   = (p / ht) % vt;
      e.hs   = (e.ph >= hs + ho && e.ph < hs + ho + hw) ? 1 : 0;
      e.vs   = (e.pv >= vs + vo && e.pv < vs + vo + vw) ? 1 : 0;
      e.hb   = (e.ph >= ha) ? 1 : 0;
      e.vb   = (e.pv >= va) ? 1 : 0;
      e.fr   = (e.pclk == 1 && e.ph == 0 && e.pv == 0) ? 1 : 0;
    end
    return e;
  endfunction

  function automatic bit small_frame(input int cyc);
    return cyc > 0 && (cyc % S_D == 0) && ((cyc / S_D) % (S_HT * S_VT) == 0);
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      if (failures <= 30)
        $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, n, obs, exp);
    end
  endtask

  task automatic check_inst(input string nm, input exp_t e, input logic pclk,
                            input logic [8:0] ph, input logic [8:0] pv, input logic hs,
                            input logic vs, input logic hb, input logic vb, input logic fr);
    check_val({nm, ".pclk_en"}, 32'(pclk), e.pclk);
    check_val({nm, ".ph"},      32'(ph),   e.ph);
    check_val({nm, ".pv"},      32'(pv),   e.pv);
    check_val({nm, ".hsync"},   32'(hs),   e.hs);
    check_val({nm, ".vsync"},   32'(vs),   e.vs);
    check_val({nm, ".hblank"},  32'(hb),   e.hb);
    check_val({nm, ".vblank"},  32'(vb),   e.vb);
    check_val({nm, ".frame"},   32'(fr),   e.fr);
  endtask

  task automatic check_all();
    check_inst("small", model(n, S_D, S_HT, S_VT, S_HA, S_VA, S_HS, S_HW, S_VS, S_VW, eff_h, eff_v),
               s_if.PCLK_EN, s_if.PH, s_if.PV, s_if.HSYNC, s_if.VSYNC, s_if.HBLANK, s_if.VBLANK,
               s_if.FRAME);
    check_inst("dflt", model(n, 8, 384, 264, 288, 224, 304, 32, 240, 8, 0, 0),
               d_if.PCLK_EN, d_if.PH, d_if.PV, d_if.HSYNC, d_if.VSYNC, d_if.HBLANK, d_if.VBLANK,
               d_if.FRAME);
  endtask

  // Edge counter since release, and the offsets the design has latched at each frame start.
  always @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      n     <= 0;
      eff_h <= 0;
      eff_v <= 0;
    end else begin
`ifdef DIGDUG_HVOFFSET_EN
      if (small_frame(n)) begin
        eff_h <= h_drv;
        eff_v <= v_drv;
      end
`endif
      n <= n + 1;
    end
  end

  always @(negedge MCLK) begin
    if (!done) check_all();
  end

  task automatic run_cycles(input int k);
    for (int i = 0; i < k; i++) begin
      @(negedge MCLK);
`ifdef DIGDUG_HVOFFSET_EN
      if ($urandom_range(0, 299) == 0) begin
        h_drv = int'($urandom_range(0, 15)) - 8;
        v_drv = int'($urandom_range(0, 15)) - 8;
      end
`endif
    end
  endtask

  initial begin
    RESET = 1'b1;
    repeat (4) @(negedge MCLK);
    RESET = 1'b0;
    run_cycles(25000);
    for (int r = 0; r < 6; r++) begin
      run_cycles(int'($urandom_range(500, 3000)));
      @(posedge MCLK);
      #3;
      RESET = 1'b1;
      #1;
      check_all();
      repeat (3) @(negedge MCLK);
      RESET = 1'b0;
    end
    run_cycles(4000);
    done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
